// File: rtl/counter_7d_pkg.sv
// Shared definitions for the counter_7d display digit: segment vector type
// and the abcdefg patterns for each hex digit (active-high, q[6]=a .. q[0]=g).
package counter_7d_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;
  localparam seg_t SEG_A     = 7'b1110111;
  localparam seg_t SEG_B     = 7'b0011111;
  localparam seg_t SEG_C     = 7'b1001110;
  localparam seg_t SEG_D     = 7'b0111101;
  localparam seg_t SEG_E     = 7'b1001111;
  localparam seg_t SEG_F     = 7'b1000111;
  localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/counter_7d_seg7_decoder.sv
// Purely combinational 4-bit value to 7-segment pattern decoder (active-high).
// Values at or above MODULUS can never be reached by the counter and show blank.
module seg7_decoder
  import counter_7d_pkg::*;
#(
  parameter int MODULUS = 10
) (
  input  logic [3:0] i_value,
  output seg_t       o_seg
);

  localparam logic [4:0] LIMIT = 5'(MODULUS);

  always_comb begin
    o_seg = SEG_BLANK;
    if ({1'b0, i_value} < LIMIT) begin
      case (i_value)
        4'h0: o_seg = SEG_0;
        4'h1: o_seg = SEG_1;
        4'h2: o_seg = SEG_2;
        4'h3: o_seg = SEG_3;
        4'h4: o_seg = SEG_4;
        4'h5: o_seg = SEG_5;
        4'h6: o_seg = SEG_6;
        4'h7: o_seg = SEG_7;
        4'h8: o_seg = SEG_8;
        4'h9: o_seg = SEG_9;
        4'hA: o_seg = SEG_A;
        4'hB: o_seg = SEG_B;
        4'hC: o_seg = SEG_C;
        4'hD: o_seg = SEG_D;
        4'hE: o_seg = SEG_E;
        4'hF: o_seg = SEG_F;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/counter_7d.sv
// Free-running modulo-MODULUS digit counter shown only as a 7-segment pattern.
// SEG_ACTIVE_LOW inverts every segment for common-anode displays.
module counter_7d
  import counter_7d_pkg::*;
#(
  parameter int MODULUS        = 10,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [6:0] q
);

  localparam logic [3:0] LAST = 4'(MODULUS - 1);

  logic [3:0] r_cnt;
  seg_t       w_seg;

  // Using >= rather than == also pulls any unreachable value back to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= 4'd0;
    else if (r_cnt >= LAST)
      r_cnt <= 4'd0;
    else
      r_cnt <= r_cnt + 4'd1;
  end

  seg7_decoder #(
    .MODULUS(MODULUS)
  ) u_decoder (
    .i_value(r_cnt),
    .o_seg  (w_seg)
  );

  assign q = SEG_ACTIVE_LOW ? ~w_seg : w_seg;

endmodule

// File: tb/tb_counter_7d.sv
// Directed bench for counter_7d: decimal, common-anode and hex variants share
// one clock and reset, and every sampled q is checked against hand-written codes.
module tb_counter_7d;

  logic       clk;
  logic       reset;
  logic [6:0] qDec;
  logic [6:0] qLow;
  logic [6:0] qHex;

  int compareCount  = 0;
  int mismatchCount = 0;

  logic [6:0] segTab [16];

  counter_7d #(.MODULUS(10), .SEG_ACTIVE_LOW(1'b0)) dutDec (
    .clk  (clk),
    .reset(reset),
    .q    (qDec)
  );

  counter_7d #(.MODULUS(10), .SEG_ACTIVE_LOW(1'b1)) dutLow (
    .clk  (clk),
    .reset(reset),
    .q    (qLow)
  );

  counter_7d #(.MODULUS(16), .SEG_ACTIVE_LOW(1'b0)) dutHex (
    .clk  (clk),
    .reset(reset),
    .q    (qHex)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [6:0] observed,
                             input logic [6:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstVal);
    reset = rstVal;
  endtask

  task automatic checkAll(input string tag, input logic [6:0] expDec,
                          input logic [6:0] expHex);
    checkOutput({tag, "_dec"}, qDec, expDec);
    checkOutput({tag, "_low"}, qLow, ~expDec);
    checkOutput({tag, "_hex"}, qHex, expHex);
  endtask

  // Watchdog so a broken clock or stuck run still ends with a report.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    segTab[0]  = 7'b1111110;
    segTab[1]  = 7'b0110000;
    segTab[2]  = 7'b1101101;
    segTab[3]  = 7'b1111001;
    segTab[4]  = 7'b0110011;
    segTab[5]  = 7'b1011011;
    segTab[6]  = 7'b1011111;
    segTab[7]  = 7'b1110000;
    segTab[8]  = 7'b1111111;
    segTab[9]  = 7'b1111011;
    segTab[10] = 7'b1110111;
    segTab[11] = 7'b0011111;
    segTab[12] = 7'b1001110;
    segTab[13] = 7'b0111101;
    segTab[14] = 7'b1001111;
    segTab[15] = 7'b1000111;

    // Reset takes effect before any clock edge and holds across edges.
    applyStimulus(1'b1);
    #1;
    checkAll("reset_async", 7'b1111110, 7'b1111110);
    checkOutput("reset_low_literal", qLow, 7'b0000001);
    for (int e = 1; e <= 2; e++) begin
      @(posedge clk);
      #1;
      checkAll($sformatf("reset_hold%0d", e), 7'b1111110, 7'b1111110);
    end

    @(negedge clk);
    applyStimulus(1'b0);

    // Decimal wraps 9->0 at edge 10; hex reaches F at edge 15 and wraps at 16.
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk);
      #1;
      checkAll($sformatf("edge%0d", n), segTab[n % 10], segTab[n % 16]);
      if (n == 8)
        checkOutput("low_eight_literal", qLow, 7'b0000000);
      if (n == 15)
        checkOutput("hex_f_literal", qHex, 7'b1000111);
      if (n == 16)
        checkOutput("hex_wrap_literal", qHex, 7'b1111110);
    end

    // Edge 17: decimal shows 7, hex shows 1.
    @(posedge clk);
    #1;
    checkAll("edge17", 7'b1110000, 7'b0110000);

    // Mid-cycle reset must clear the display before the next clock edge.
    #4;
    applyStimulus(1'b1);
    #1;
    checkAll("mid_reset", 7'b1111110, 7'b1111110);
    #2;
    applyStimulus(1'b0);
    #1;
    checkAll("mid_release", 7'b1111110, 7'b1111110);

    @(posedge clk);
    #1;
    checkAll("resume", 7'b0110000, 7'b0110000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
